// File: rtl/lstm_sec_pkg.sv
// lstm_sec_pkg: trace record layout shared by the trace FIFO and the softmax stage.
//   REC_W    : record width (type bit + 12-bit address/ID)
//   TYPE_BIT : bit position of the record type
//   SYS_TYPE : type value of a SYS record
//   BR_TYPE  : type value of a BR record
package lstm_sec_pkg;

  localparam int   REC_W    = 13;
  localparam int   TYPE_BIT = 12;
  localparam logic SYS_TYPE = 1'b1;
  localparam logic BR_TYPE  = 1'b0;

  typedef logic [REC_W-1:0] rec_t;

  // Record type classification, used by consumers of the trace stream.
  function automatic logic rec_is_sys(input rec_t r);
    return r[TYPE_BIT] == SYS_TYPE;
  endfunction

  function automatic logic rec_is_br(input rec_t r);
    return r[TYPE_BIT] == BR_TYPE;
  endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// trace_fifo_mem: DEPTH x REC_W register array, one synchronous write port and
// one asynchronous (combinational) read port. Contents are not reset; validity
// is tracked by the owning FIFO.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational)
module trace_fifo_mem
  import lstm_sec_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  rec_t          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output rec_t          rdata_o
);

  rec_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_fifo.sv
// trace_fifo: first-word-fall-through FIFO buffering CPU trace records for the
// softmax stage. The tracer cannot be stalled, so a push into a full FIFO
// (with no pop in the same cycle) is dropped and flagged.
// Optional feature: define TRACE_FIFO_DROP_CNT_EN to add the 16-bit saturating
// dropped-record counter and its oDrop_cnt port.
//   clk          : clock, all state on rising edge
//   reset        : asynchronous active-high reset
//   iPush_valid  : record present from tracer
//   iPush_data   : record (bit 12 type, 11:0 address/ID)
//   oFIFO_valid  : head record available
//   oFIFO_data   : head record, zero when empty
//   iFIFO_ready  : consumer takes the head this cycle
//   iClr_ovf     : clear overflow flag (and drop counter)
//   oCount       : occupancy
//   oAlmost_full : oCount >= AFULL_TH
//   oOverflow    : sticky drop flag
//   oDrop_cnt    : dropped-record count (TRACE_FIFO_DROP_CNT_EN only)
module trace_fifo
  import lstm_sec_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iPush_valid,
  input  logic [REC_W-1:0]         iPush_data,
  output logic                     oFIFO_valid,
  output logic [REC_W-1:0]         oFIFO_data,
  input  logic                     iFIFO_ready,
  input  logic                     iClr_ovf,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oAlmost_full,
  output logic                     oOverflow
`ifdef TRACE_FIFO_DROP_CNT_EN
  ,output logic [15:0]             oDrop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_TH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;

  logic empty, full, pop, push, drop;
  rec_t rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  // Empty gates ready so a pop on empty can never move the read pointer.
  assign pop   = !empty && iFIFO_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = iPush_valid && (!full || pop);
  assign drop  = iPush_valid && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap by natural overflow.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // A drop in the clear cycle wins so the event is not lost.
    ovf_d = (ovf_q && !iClr_ovf) || drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef TRACE_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (iClr_ovf)                      drop_cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign oDrop_cnt = drop_cnt_q;
`endif

  trace_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (iPush_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign oFIFO_valid  = !empty;
  // Stale storage must not leak out when nothing is held.
  assign oFIFO_data   = empty ? '0 : rdata;
  assign oCount       = count_q;
  assign oAlmost_full = (count_q >= AFULL_CNT);
  assign oOverflow    = ovf_q;

endmodule

// File: tb/tb_trace_fifo.sv
// tb_trace_fifo: directed scenarios with literal expectations plus randomized
// traffic, all checked against a queue-based reference model.
module tb_trace_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push_v = 1'b0;
  logic [12:0] push_d = '0;
  logic        ready = 1'b0;
  logic        clr = 1'b0;
  logic        f_valid;
  logic [12:0] f_data;
  logic [4:0]  count;
  logic        afull;
  logic        ovf;
`ifdef TRACE_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  logic [12:0] mq[$];
  bit          m_ovf = 1'b0;
  int          m_drop = 0;

  always #5 clk = ~clk;

  trace_fifo #(.DEPTH(DEPTH), .AFULL_TH(AFULL)) dut (
    .clk          (clk),
    .reset        (reset),
    .iPush_valid  (push_v),
    .iPush_data   (push_d),
    .oFIFO_valid  (f_valid),
    .oFIFO_data   (f_data),
    .iFIFO_ready  (ready),
    .iClr_ovf     (clr),
    .oCount       (count),
    .oAlmost_full (afull),
    .oOverflow    (ovf)
`ifdef TRACE_FIFO_DROP_CNT_EN
    ,.oDrop_cnt   (drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, evaluated on the pre-edge state.
  task automatic model_step(input bit pv, input logic [12:0] pd, input bit rdy, input bit c);
    int  n;
    bit  pop, full;
    n    = mq.size();
    pop  = (n != 0) && rdy;
    full = (n == DEPTH);
    if (c) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (pv && full && !pop) begin
      m_ovf = 1'b1;
      if (m_drop != 65535) m_drop++;
    end
    if (pop) void'(mq.pop_front());
    if (pv && (!full || pop)) mq.push_back(pd);
  endtask

  // Called at negedge+1; returns at next negedge+1 with the edge applied.
  task automatic cycle(input bit pv, input logic [12:0] pd, input bit rdy, input bit c);
    push_v = pv; push_d = pd; ready = rdy; clr = c;
    if (!reset) model_step(pv, pd, rdy, c);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // Compare process: outputs against the model every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid", 32'(f_valid), 32'(mq.size() != 0));
      chk("data",  32'(f_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      chk("count", 32'(count),   32'(mq.size()));
      chk("afull", 32'(afull),   32'(mq.size() >= AFULL));
      chk("ovf",   32'(ovf),     32'(m_ovf));
`ifdef TRACE_FIFO_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    end
  end

  initial begin
    logic [31:0] r;
    int pp, rp;

    // Reset state
    @(negedge clk); #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(f_valid), 32'd0);
    chk("rst_data", 32'(f_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_afull", 32'(afull), 32'd0);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Single push into empty: visible after one edge
    cycle(1, 13'h0A2F, 0, 0);
    chk("s1_valid", 32'(f_valid), 32'd1);
    chk("s1_data", 32'(f_data), 32'h0A2F);
    chk("s1_count", 32'(count), 32'd1);
    cycle(0, 0, 1, 0);
    chk("s1_drain", 32'(f_valid), 32'd0);

    // Order preservation
    cycle(1, 13'h011A, 0, 0);
    cycle(1, 13'h1DC0, 0, 0);
    cycle(1, 13'h02E9, 0, 0);
    chk("s2_head0", 32'(f_data), 32'h011A);
    cycle(0, 0, 1, 0);
    chk("s2_head1", 32'(f_data), 32'h1DC0);
    cycle(0, 0, 1, 0);
    chk("s2_head2", 32'(f_data), 32'h02E9);
    cycle(0, 0, 1, 0);
    chk("s2_valid", 32'(f_valid), 32'd0);
    chk("s2_data", 32'(f_data), 32'd0);
    cycle(0, 0, 1, 0);  // ready on empty: nothing moves
    chk("s2_empty_rdy", 32'(count), 32'd0);

    // Fill, then drop on full
    for (int i = 0; i < DEPTH; i++) cycle(1, 13'(13'h0100 + i), 0, 0);
    chk("s3_full", 32'(count), 32'd16);
    cycle(1, 13'h110C, 0, 0);
    chk("s3_count", 32'(count), 32'd16);
    chk("s3_ovf", 32'(ovf), 32'd1);
`ifdef TRACE_FIFO_DROP_CNT_EN
    chk("s3_drop", 32'(drop_cnt), 32'd1);
    cycle(1, 13'h1111, 0, 1);  // drop coincident with clear
    chk("s3_drop_clr", 32'(drop_cnt), 32'd1);
`else
    cycle(1, 13'h1111, 0, 1);
`endif
    chk("s3_ovf_clr_drop", 32'(ovf), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("s3_pop", 32'(f_data), 32'(13'h0100 + i));
      cycle(0, 0, 1, 0);
    end
    cycle(0, 0, 0, 1);
    chk("s3_clr", 32'(ovf), 32'd0);

    // Push while full with a simultaneous pop
    for (int i = 0; i < DEPTH; i++) cycle(1, 13'(13'h0200 + i), 0, 0);
    cycle(1, 13'h109A, 1, 0);
    chk("s4_count", 32'(count), 32'd16);
    chk("s4_ovf", 32'(ovf), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      chk("s4_pop", 32'(f_data), 32'(13'h0200 + i));
      cycle(0, 0, 1, 0);
    end
    chk("s4_last", 32'(f_data), 32'h109A);
    cycle(0, 0, 1, 0);
    chk("s4_empty", 32'(f_valid), 32'd0);

    // Almost-full threshold
    for (int i = 0; i < AFULL - 1; i++) cycle(1, 13'(i), 0, 0);
    chk("s5_below", 32'(afull), 32'd0);
    cycle(1, 13'h0ABC, 0, 0);
    chk("s5_rise", 32'(afull), 32'd1);
    cycle(0, 0, 1, 0);
    chk("s5_fall", 32'(afull), 32'd0);
    for (int i = 0; i < AFULL - 1; i++) cycle(0, 0, 1, 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) cycle(1, 13'(13'h0300 + i), 0, 0);
    reset = 1'b1;
    model_reset();
    #1;
    chk("s6_count", 32'(count), 32'd0);
    chk("s6_valid", 32'(f_valid), 32'd0);
    chk("s6_data", 32'(f_data), 32'd0);
    cycle(1, 13'h0777, 1, 0);  // ignored while in reset
    reset = 1'b0;
    cycle(1, 13'h1029, 0, 0);
    chk("s6_head", 32'(f_data), 32'h1029);
    chk("s6_cnt", 32'(count), 32'd1);

    // Randomized traffic in phases of varying push/pop pressure
    for (int ph = 0; ph < 12; ph++) begin
      pp = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 50 : 20;
      rp = (ph % 4 == 0) ? 15 : (ph % 4 == 1) ? 60 : (ph % 4 == 2) ? 90 : 40;
      for (int k = 0; k < 200; k++) begin
        r = $urandom();
        cycle($urandom_range(0, 99) < pp, r[12:0], $urandom_range(0, 99) < rp,
              $urandom_range(0, 99) < 3);
      end
      if (ph == 6) begin
        reset = 1'b1;
        model_reset();
        cycle(0, 0, 0, 0);
        reset = 1'b0;
      end
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_fifo.md
TRACE_FIFO -- requirements
Module: trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of 2, minimum 4).
REQ-002 SHALL have parameter AFULL_TH, default 12, occupancy at or above which oAlmost_full asserts.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port iPush_valid  input  1  trace record present from the CPU tracer (no backpressure).
REQ-006 SHALL have port iPush_data  input  13  record: bit 12 = type (1 = SYS, 0 = BR), bits 11:0 = address/ID.
REQ-007 SHALL have port oFIFO_valid  output  1  head record available to the softmax stage.
REQ-008 SHALL have port oFIFO_data  output  13  head record.
REQ-009 SHALL have port iFIFO_ready  input  1  softmax stage accepts the head this cycle.
REQ-010 SHALL have port iClr_ovf  input  1  clears the overflow flag and the drop counter.
REQ-011 SHALL have port oCount  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port oAlmost_full  output  1  oCount >= AFULL_TH.
REQ-013 SHALL have port oOverflow  output  1  sticky flag: a record was dropped.
REQ-014 SHALL have port oDrop_cnt  output  16  dropped-record count; present only with TRACE_FIFO_DROP_CNT_EN.

Function
REQ-015 SHALL implement first-word-fall-through: oFIFO_valid = (oCount != 0); oFIFO_data = head entry, forced to 13'h0000 when empty.
REQ-016 SHALL pop when oFIFO_valid && iFIFO_ready; the read pointer advances next edge.
REQ-017 SHALL accept a push when iPush_valid && (not full, or a pop occurs in the same cycle).
REQ-018 SHALL apply push-to-visible latency of 1 cycle: a record pushed into an empty FIFO at edge N gives oFIFO_valid=1 after edge N.
REQ-019 SHALL leave oCount unchanged and write at the tail while reading the head on a simultaneous push and pop.
REQ-020 SHALL ignore iFIFO_ready when empty; a pop on empty SHALL never occur and the pointers SHALL not move.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH; full is oCount == DEPTH.
REQ-022 SHALL discard a push that arrives when full with no pop, leave FIFO contents unchanged, and set oOverflow=1.
REQ-023 SHALL keep oOverflow set until iClr_ovf; a new drop in the same cycle as iClr_ovf leaves oOverflow=1.
REQ-024 SHALL preserve record order exactly and never alter record bits.

Reset
REQ-025 SHALL, while reset=1, asynchronously clear pointers, oCount=0, oFIFO_valid=0, oFIFO_data=0, oAlmost_full=0, oOverflow=0, oDrop_cnt=0.
REQ-026 SHALL discard all stored records on a reset asserted mid-operation; storage contents need not be cleared.
REQ-027 SHALL accept the first push on the first rising edge after reset deasserts.

Configuration
REQ-028 SHALL, with TRACE_FIFO_DROP_CNT_EN defined, increment oDrop_cnt per dropped record, saturate at 16'hFFFF, and clear it on iClr_ovf (a drop in the same cycle as iClr_ovf gives 1).
REQ-029 SHALL, without TRACE_FIFO_DROP_CNT_EN, omit the oDrop_cnt port and its counter; all other behaviour is identical.

Structure
REQ-030 SHALL take REC_W=13, TYPE_BIT=12, SYS_TYPE=1'b1 and BR_TYPE=1'b0 from shared package lstm_sec_pkg, which the softmax stage also uses.
REQ-031 SHALL place storage in sub-module trace_fifo_mem: a DEPTH x 13 register array with one write port and one asynchronous read port; pointers, count and flags stay in trace_fifo.

Verification
REQ-032 Scenario: after reset, push 13'h0A2F for 1 cycle with iFIFO_ready=0 -> next cycle oFIFO_valid=1, oFIFO_data=13'h0A2F, oCount=1.
REQ-033 Scenario: push 13'h011A, 13'h1DC0, 13'h02E9 back-to-back, then iFIFO_ready=1 -> pops in that order, oFIFO_valid=0 and oFIFO_data=0 afterwards.
REQ-034 Scenario: fill 16 entries, then push 13'h110C with no pop -> oCount=16, oOverflow=1, oDrop_cnt=1, the next 16 pops return the original records.
REQ-035 Scenario: when full, push 13'h109A with iFIFO_ready=1 -> oCount stays 16, no drop, 13'h109A is popped 16th.
REQ-036 Scenario: push 12 records -> oAlmost_full rises on the 12th; pop 1 -> it falls.
REQ-037 Scenario: assert reset with 5 entries stored -> oCount=0 and oFIFO_valid=0 immediately; after release, push 13'h1029 -> 13'h1029 is the head.
